fft8_frame_loader: RTL and testbench
====================================

FFT8_FRAME_LOADER -- requirements
Module: fft8_frame_loader

Interface
REQ-001: Parameter DW, default 16, width of each real/imaginary sample component (two's complement).
REQ-002: Parameter N, default 8, frame length in samples (fixed at 8; log2 = 3).
REQ-003: clk  input  1  sole clock; all state updates on rising edge.
REQ-004: rst_n  input  1  asynchronous, active-low reset.
REQ-005: in_valid  input  1  serial sample present.
REQ-006: in_ready  output  1  loader can accept a sample this cycle.
REQ-007: in_re, in_im  input  DW each  serial complex sample, natural time order.
REQ-008: in_last  input  1  marks final sample of a frame.
REQ-009: x_re, x_im  output  DW x 8 arrays each  parallel frame to FFT, bit-reversed slot order.
REQ-010: out_valid  output  1  x_re/x_im hold a complete frame.
REQ-011: out_ready  input  1  FFT side consumes presented frame.
REQ-012: frame_err  output  1  one-cycle pulse on framing error.

Function
REQ-013: Two frame banks (A, B), each 8 complex entries; write side and read side each hold a bank pointer, initially A; per-bank full flag.
REQ-014: in_ready SHALL equal NOT full[wr_bank] (combinational).
REQ-015: Sample accepted when in_valid AND in_ready; stored in bank[wr_bank] slot bitrev3(wr_idx) (0->0,1->4,2->2,3->6,4->1,5->5,6->3,7->7); wr_idx increments mod 8.
REQ-016: On accept with wr_idx=7: full[wr_bank] set, wr_bank toggles, wr_idx -> 0.
REQ-017: out_valid SHALL equal full[rd_bank]; x_re/x_im SHALL drive bank[rd_bank] contents directly.
REQ-018: Frame release when out_valid AND out_ready: full[rd_bank] cleared, rd_bank toggles; presented data stable and unchanged while out_valid=1 and out_ready=0.
REQ-019: Latency: out_valid rises the cycle after the 8th sample is accepted (when that bank is the read bank).
REQ-020: Throughput: continuous 1 sample/cycle sustained if each frame released within 8 cycles of out_valid.
REQ-021: Simultaneous fill-complete on one bank and release of the other in same cycle SHALL both take effect; out_valid stays 1, new frame presented next cycle.
REQ-022: in_last with wr_idx<7 (early): frame_err pulses next cycle, partial frame discarded (wr_idx -> 0, full unchanged, wr_bank unchanged).
REQ-023: in_last=0 with wr_idx=7 (missing): frame still completes per REQ-016; frame_err pulses next cycle.
REQ-024: Samples with in_valid=1, in_ready=0 SHALL not be stored and SHALL not affect wr_idx or frame_err.
REQ-025: No arithmetic on sample data; values pass bit-exact.

Reset
REQ-026: While rst_n=0: out_valid=0, frame_err=0, all bank entries 0 (x_re/x_im all 0), full flags 0, wr_idx=0, wr_bank=rd_bank=A; in_ready=1.
REQ-027: Reset asserted mid-frame discards all partial and complete frames; first sample after release of reset is sample 0 of a new frame.

Verification
REQ-028: Reset: hold rst_n=0 -> out_valid=0, in_ready=1, frame_err=0, all x_re/x_im=0.
REQ-029: Single frame: 8 samples re=k+1, im=-(k+1), in_last on 8th, out_ready=0 -> out_valid one cycle after 8th accept; x_re = {1,5,3,7,2,6,4,8} for slots 0..7, x_im the negatives.
REQ-030: Backpressure: out_ready=0, 24 samples offered back-to-back -> exactly 16 accepted, in_ready=0 after 16th, x_re shows frame 1 unchanged; pulse out_ready one cycle -> frame 2 presented next cycle, in_ready=1.
REQ-031: Early last: in_last on 3rd sample -> frame_err pulse one cycle, no out_valid; following 8 well-formed samples produce a correct frame.
REQ-032: Reset mid-frame: 5 samples accepted, rst_n pulsed low -> out_valid stays 0; next 8 samples form a correct frame.
REQ-033: Simultaneous: frame 1 presented, out_ready=1 in same cycle as 8th sample of frame 2 accepted -> out_valid remains 1, x_re switches to frame 2 next cycle, no frame lost or duplicated.

Source files
------------

// File: rtl/fft8_frame_loader.sv
// Serial-to-parallel loader for an 8-point FFT.
// Double-buffers complex samples into bit-reversed slot order.
module fft8_frame_loader #(
   parameter int unsigned DW = 16,
   parameter int unsigned N  = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DW-1:0]          in_re,
   input  logic [DW-1:0]          in_im,
   input  logic                   in_last,
   output logic [N-1:0][DW-1:0]   x_re,
   output logic [N-1:0][DW-1:0]   x_im,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   frame_err
);

   localparam int unsigned IW = 3;
   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

   logic [N-1:0][DW-1:0] bank_re_q [2];
   logic [N-1:0][DW-1:0] bank_re_d [2];
   logic [N-1:0][DW-1:0] bank_im_q [2];
   logic [N-1:0][DW-1:0] bank_im_d [2];
   logic [1:0]           full_q, full_d;
   logic                 wr_bank_q, wr_bank_d;
   logic                 rd_bank_q, rd_bank_d;
   logic [IW-1:0]        wr_idx_q, wr_idx_d;
   logic                 frame_err_q, frame_err_d;
   logic                 accept, release_frame;

   function automatic logic [IW-1:0] bitrev3(input logic [IW-1:0] i);
      return {i[0], i[1], i[2]};
   endfunction

   assign in_ready      = ~full_q[wr_bank_q];
   assign out_valid     = full_q[rd_bank_q];
   assign x_re          = bank_re_q[rd_bank_q];
   assign x_im          = bank_im_q[rd_bank_q];
   assign frame_err     = frame_err_q;
   assign accept        = in_valid & in_ready;
   assign release_frame = out_valid & out_ready;

   // Fill and release may hit different banks in the same cycle; both apply.
   always_comb begin
      bank_re_d   = bank_re_q;
      bank_im_d   = bank_im_q;
      full_d      = full_q;
      wr_bank_d   = wr_bank_q;
      rd_bank_d   = rd_bank_q;
      wr_idx_d    = wr_idx_q;
      frame_err_d = 1'b0;

      if (accept) begin
         if (wr_idx_q == LAST_IDX) begin
            bank_re_d[wr_bank_q][bitrev3(wr_idx_q)] = in_re;
            bank_im_d[wr_bank_q][bitrev3(wr_idx_q)] = in_im;
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
            wr_idx_d          = '0;
            frame_err_d       = ~in_last;
         end else if (in_last) begin
            // Early end of frame: drop the partial frame and restart at slot 0.
            wr_idx_d    = '0;
            frame_err_d = 1'b1;
         end else begin
            bank_re_d[wr_bank_q][bitrev3(wr_idx_q)] = in_re;
            bank_im_d[wr_bank_q][bitrev3(wr_idx_q)] = in_im;
            wr_idx_d = wr_idx_q + IW'(1);
         end
      end

      if (release_frame) begin
         full_d[rd_bank_q] = 1'b0;
         rd_bank_d         = ~rd_bank_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank_re_q   <= '{default: '0};
         bank_im_q   <= '{default: '0};
         full_q      <= '0;
         wr_bank_q   <= 1'b0;
         rd_bank_q   <= 1'b0;
         wr_idx_q    <= '0;
         frame_err_q <= 1'b0;
      end else begin
         bank_re_q   <= bank_re_d;
         bank_im_q   <= bank_im_d;
         full_q      <= full_d;
         wr_bank_q   <= wr_bank_d;
         rd_bank_q   <= rd_bank_d;
         wr_idx_q    <= wr_idx_d;
         frame_err_q <= frame_err_d;
      end
   end

endmodule

// File: tb/tb_fft8_frame_loader.sv
// Directed self-checking bench for fft8_frame_loader.
module tb_fft8_frame_loader;

   localparam int unsigned DW = 16;
   localparam int unsigned N  = 8;

   logic                 clk;
   logic                 rst_n;
   logic                 in_valid;
   logic                 in_ready;
   logic [DW-1:0]        in_re;
   logic [DW-1:0]        in_im;
   logic                 in_last;
   logic [N-1:0][DW-1:0] x_re;
   logic [N-1:0][DW-1:0] x_im;
   logic                 out_valid;
   logic                 out_ready;
   logic                 frame_err;

   int vecs = 0;
   int errs = 0;
   int br [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

   fft8_frame_loader #(.DW(DW), .N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_re     (in_re),
      .in_im     (in_im),
      .in_last   (in_last),
      .x_re      (x_re),
      .x_im      (x_im),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .frame_err (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One sample offered for one cycle; outputs are sampled 1 time unit after the edge.
   task automatic send(input int re, input int im, input logic last);
      in_valid = 1'b1;
      in_re    = DW'(re);
      in_im    = DW'(im);
      in_last  = last;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic idle_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic release_one();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      @(posedge clk);
      #1;
      vecs++;
      if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      vecs++;
      if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      vecs++;
      if (frame_err !== 1'b0) begin errs++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
      vecs++;
      if (x_re !== '0 || x_im !== '0) begin errs++; $display("FAIL reset_x got %h/%h want 0", x_re, x_im); end
      @(posedge clk);
      #1 rst_n = 1'b1;
      idle_cycle();
   endtask

   task automatic test_single_frame();
      for (int k = 0; k < 7; k++) send(k + 1, -(k + 1), 1'b0);
      vecs++;
      if (out_valid !== 1'b0) begin errs++; $display("FAIL single_early_valid got %b want 0", out_valid); end
      send(8, -8, 1'b1);
      vecs++;
      if (out_valid !== 1'b1) begin errs++; $display("FAIL single_valid got %b want 1", out_valid); end
      vecs++;
      if (frame_err !== 1'b0) begin errs++; $display("FAIL single_err got %b want 0", frame_err); end
      for (int s = 0; s < 8; s++) begin
         logic [DW-1:0] er, ei;
         er = DW'(1 + br[s]);
         ei = DW'(-(1 + br[s]));
         vecs++;
         if (x_re[s] !== er || x_im[s] !== ei)
            begin errs++; $display("FAIL single_slot%0d got %0d/%0d want %0d/%0d", s, x_re[s], x_im[s], er, ei); end
      end
      release_one();
      vecs++;
      if (out_valid !== 1'b0) begin errs++; $display("FAIL single_release got %b want 0", out_valid); end
   endtask

   task automatic test_backpressure();
      int acc;
      acc = 0;
      out_ready = 1'b0;
      for (int k = 0; k < 24; k++) begin
         in_valid = 1'b1;
         in_re    = DW'(100 + acc);
         in_im    = DW'(200 + acc);
         in_last  = ((acc % 8) == 7);
         if (in_ready) acc++;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      vecs++;
      if (acc !== 16) begin errs++; $display("FAIL bp_accepted got %0d want 16", acc); end
      vecs++;
      if (in_ready !== 1'b0) begin errs++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
      for (int s = 0; s < 8; s++) begin
         vecs++;
         if (x_re[s] !== DW'(100 + br[s]) || x_im[s] !== DW'(200 + br[s]))
            begin errs++; $display("FAIL bp_f1_slot%0d got %0d/%0d want %0d/%0d", s, x_re[s], x_im[s], 100 + br[s], 200 + br[s]); end
      end
      release_one();
      vecs++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1)
         begin errs++; $display("FAIL bp_after_release got valid=%b ready=%b want 1/1", out_valid, in_ready); end
      for (int s = 0; s < 8; s++) begin
         vecs++;
         if (x_re[s] !== DW'(108 + br[s]) || x_im[s] !== DW'(208 + br[s]))
            begin errs++; $display("FAIL bp_f2_slot%0d got %0d/%0d want %0d/%0d", s, x_re[s], x_im[s], 108 + br[s], 208 + br[s]); end
      end
      release_one();
      vecs++;
      if (out_valid !== 1'b0) begin errs++; $display("FAIL bp_drained got %b want 0", out_valid); end
   endtask

   task automatic test_early_last();
      send(1, 1, 1'b0);
      send(2, 2, 1'b0);
      send(3, 3, 1'b1);
      vecs++;
      if (frame_err !== 1'b1) begin errs++; $display("FAIL early_err_pulse got %b want 1", frame_err); end
      idle_cycle();
      vecs++;
      if (frame_err !== 1'b0) begin errs++; $display("FAIL early_err_clear got %b want 0", frame_err); end
      vecs++;
      if (out_valid !== 1'b0) begin errs++; $display("FAIL early_no_valid got %b want 0", out_valid); end
      for (int k = 0; k < 8; k++) send(20 + k, 30 + k, k == 7);
      for (int s = 0; s < 8; s++) begin
         vecs++;
         if (out_valid !== 1'b1 || x_re[s] !== DW'(20 + br[s]) || x_im[s] !== DW'(30 + br[s]))
            begin errs++; $display("FAIL early_frame_slot%0d got v=%b %0d/%0d want 1 %0d/%0d", s, out_valid, x_re[s], x_im[s], 20 + br[s], 30 + br[s]); end
      end
      release_one();
   endtask

   task automatic test_missing_last();
      for (int k = 0; k < 8; k++) send(50 + k, 55 + k, 1'b0);
      vecs++;
      if (frame_err !== 1'b1 || out_valid !== 1'b1)
         begin errs++; $display("FAIL missing_last got err=%b valid=%b want 1/1", frame_err, out_valid); end
      vecs++;
      if (x_re[1] !== DW'(54) || x_im[7] !== DW'(62))
         begin errs++; $display("FAIL missing_last_data got %0d/%0d want 54/62", x_re[1], x_im[7]); end
      release_one();
      vecs++;
      if (frame_err !== 1'b0) begin errs++; $display("FAIL missing_last_clear got %b want 0", frame_err); end
   endtask

   task automatic test_reset_mid_frame();
      for (int k = 0; k < 5; k++) send(90 + k, 95 + k, 1'b0);
      rst_n = 1'b0;
      #1;
      vecs++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || x_re !== '0)
         begin errs++; $display("FAIL rstmid_state got v=%b r=%b x0=%0d want 0/1/0", out_valid, in_ready, x_re[0]); end
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int k = 0; k < 8; k++) send(40 + k, 45 + k, k == 7);
      for (int s = 0; s < 8; s++) begin
         vecs++;
         if (out_valid !== 1'b1 || x_re[s] !== DW'(40 + br[s]) || x_im[s] !== DW'(45 + br[s]))
            begin errs++; $display("FAIL rstmid_slot%0d got v=%b %0d/%0d want 1 %0d/%0d", s, out_valid, x_re[s], x_im[s], 40 + br[s], 45 + br[s]); end
      end
      release_one();
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 8; k++) send(60 + k, 65 + k, k == 7);
      for (int k = 0; k < 7; k++) send(70 + k, 75 + k, 1'b0);
      vecs++;
      if (x_re[0] !== DW'(60) || out_valid !== 1'b1)
         begin errs++; $display("FAIL b2b_f1 got v=%b x0=%0d want 1 60", out_valid, x_re[0]); end
      out_ready = 1'b1;
      send(77, 82, 1'b1);
      out_ready = 1'b0;
      vecs++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1)
         begin errs++; $display("FAIL b2b_flags got v=%b r=%b want 1/1", out_valid, in_ready); end
      for (int s = 0; s < 8; s++) begin
         vecs++;
         if (x_re[s] !== DW'(70 + br[s]) || x_im[s] !== DW'(75 + br[s]))
            begin errs++; $display("FAIL b2b_f2_slot%0d got %0d/%0d want %0d/%0d", s, x_re[s], x_im[s], 70 + br[s], 75 + br[s]); end
      end
      release_one();
      vecs++;
      if (out_valid !== 1'b0) begin errs++; $display("FAIL b2b_no_dup got %b want 0", out_valid); end
   endtask

   initial begin
      rst_n     = 1'b1;
      in_valid  = 1'b0;
      in_re     = '0;
      in_im     = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      test_reset();
      test_single_frame();
      test_backpressure();
      test_early_last();
      test_missing_last();
      test_reset_mid_frame();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
